// File: rtl/dino_screen_pkg.sv
// Shared types and screen geometry for the dino game screen/tile memory path.
package dino_screen_pkg;

    localparam int unsigned SCREEN_COLS = 40;
    localparam int unsigned SCREEN_ROWS = 30;

    typedef enum logic [1:0] {
        OP_CLEAR     = 2'd0,
        OP_FILL_RECT = 2'd1,
        OP_PUT       = 2'd2,
        OP_NOP       = 2'd3
    } tile_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } tile_wr_state_t;

endpackage

// File: rtl/screen_tile_writer_if.sv
// Command handshake plus screen-memory write port of the tile writer.
interface screen_tile_writer_if
    import dino_screen_pkg::*;
#(
    parameter int unsigned Nloc  = 1200,
    parameter int unsigned Dbits = 4,
    parameter int unsigned COLS  = SCREEN_COLS,
    parameter int unsigned ROWS  = SCREEN_ROWS
)();

    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned WW = $clog2(COLS) + 1;
    localparam int unsigned HW = $clog2(ROWS) + 1;
    localparam int unsigned AW = $clog2(Nloc);

    logic             cmd_valid;
    logic             cmd_ready;
    tile_op_t         cmd_op;
    logic [XW-1:0]    cmd_x;
    logic [YW-1:0]    cmd_y;
    logic [WW-1:0]    cmd_w;
    logic [HW-1:0]    cmd_h;
    logic [Dbits-1:0] cmd_tile;

    logic             wr;
    logic [AW-1:0]    addr;
    logic [Dbits-1:0] din;
    logic             busy;
    logic             done;

    // Command issuer (game logic) side
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_tile,
        input  cmd_ready, wr, addr, din, busy, done
    );

    // Write engine side
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_tile,
        output cmd_ready, wr, addr, din, busy, done
    );

endinterface

// File: rtl/screen_tile_writer.sv
// Turns CLEAR / FILL_RECT / PUT commands into row-major bursts of single-cycle
// writes on the screen memory write port, clipped to the visible screen.
module screen_tile_writer
    import dino_screen_pkg::*;
#(
    parameter int unsigned Nloc  = 1200,
    parameter int unsigned Dbits = 4,
    parameter int unsigned COLS  = SCREEN_COLS,
    parameter int unsigned ROWS  = SCREEN_ROWS
)(
    input  logic                 clock,
    input  logic                 reset,
    screen_tile_writer_if.slave  bus
);

    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned WW = $clog2(COLS) + 1;
    localparam int unsigned HW = $clog2(ROWS) + 1;
    localparam int unsigned AW = $clog2(Nloc);

    tile_wr_state_t state;

    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [WW-1:0] nw;
    logic [HW-1:0] nh;
    logic [WW-1:0] x_room;
    logic [HW-1:0] y_room;
    logic [WW-1:0] w_eff;
    logic [HW-1:0] h_eff;
    logic          empty;
    logic [XW-1:0] x_last_c;
    logic [AW-1:0] row_base_c;
    logic [AW-1:0] next_row_base;

    logic [XW-1:0] col;
    logic [XW-1:0] x_first;
    logic [XW-1:0] x_last;
    logic [HW-1:0] rows_left;
    logic [AW-1:0] row_base;

    // Normalise and clip the presented command so a burst never leaves the screen
    always_comb begin
        nx = bus.cmd_x;
        ny = bus.cmd_y;
        nw = bus.cmd_w;
        nh = bus.cmd_h;
        case (bus.cmd_op)
            OP_CLEAR: begin
                nx = '0;
                ny = '0;
                nw = WW'(COLS);
                nh = HW'(ROWS);
            end
            OP_PUT: begin
                nw = WW'(1);
                nh = HW'(1);
            end
            default: ;
        endcase

        // Room values wrap when the origin is off-screen; empty masks that case
        x_room = WW'(COLS) - WW'(nx);
        y_room = HW'(ROWS) - HW'(ny);
        w_eff  = (nw < x_room) ? nw : x_room;
        h_eff  = (nh < y_room) ? nh : y_room;

        empty = (bus.cmd_op == OP_NOP) ||
                (32'(nx) >= COLS) || (32'(ny) >= ROWS) ||
                (nw == '0) || (nh == '0);

        x_last_c      = XW'(WW'(nx) + w_eff - WW'(1));
        row_base_c    = AW'(ny) * AW'(COLS);
        next_row_base = row_base + AW'(COLS);
    end

    // Sequencer: all handshake and memory outputs are registered here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.wr        <= 1'b0;
            bus.addr      <= '0;
            bus.din       <= '0;
            bus.done      <= 1'b0;
            col           <= '0;
            x_first       <= '0;
            x_last        <= '0;
            rows_left     <= '0;
            row_base      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (empty) begin
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            bus.wr    <= 1'b1;
                            bus.addr  <= row_base_c + AW'(nx);
                            bus.din   <= Dbits'(bus.cmd_tile);
                            col       <= nx;
                            x_first   <= nx;
                            x_last    <= x_last_c;
                            row_base  <= row_base_c;
                            rows_left <= h_eff - HW'(1);
                            state     <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (col == x_last) begin
                        if (rows_left == '0) begin
                            bus.wr   <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            col       <= x_first;
                            row_base  <= next_row_base;
                            rows_left <= rows_left - HW'(1);
                            bus.addr  <= next_row_base + AW'(x_first);
                        end
                    end else begin
                        col      <= col + XW'(1);
                        bus.addr <= bus.addr + AW'(1);
                    end
                end

                ST_DONE: begin
                    bus.done      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_tile_writer.sv
// Scoreboard bench for screen_tile_writer driving a modelled dual-port screen memory.
module tb_screen_tile_writer;
    import dino_screen_pkg::*;

    localparam int unsigned NLOC  = 1200;
    localparam int unsigned DBITS = 4;
    localparam int unsigned COLS  = 40;
    localparam int unsigned ROWS  = 30;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  din;
    } exp_t;

    logic clock;
    logic reset;

    screen_tile_writer_if #(.Nloc(NLOC), .Dbits(DBITS), .COLS(COLS), .ROWS(ROWS)) bus ();

    screen_tile_writer #(.Nloc(NLOC), .Dbits(DBITS), .COLS(COLS), .ROWS(ROWS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Screen memory: write port from the engine, addr2 read port for checking
    logic [3:0]  mem [NLOC];
    logic [10:0] addr2;
    logic [3:0]  dout2;

    always @(posedge clock) begin
        if (bus.wr) mem[bus.addr] <= bus.din;
    end
    assign dout2 = mem[addr2];

    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every issued write must match the next scoreboard entry
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.wr) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.addr), 32'(e.addr));
                check("wr_din", 32'(bus.din), 32'(e.din));
            end
        end
    end

    task automatic push_expected(input int op, input int x, input int y, input int w,
                                 input int h, input int tile, output int n);
        int   nx, ny, nw, nh;
        exp_t e;
        nx = x; ny = y; nw = w; nh = h;
        if (op == 0) begin
            nx = 0; ny = 0; nw = COLS; nh = ROWS;
        end else if (op == 2) begin
            nw = 1; nh = 1;
        end else if (op == 3) begin
            nw = 0;
        end
        n = 0;
        for (int r = ny; r < ny + nh && r < int'(ROWS); r++) begin
            for (int c = nx; c < nx + nw && c < int'(COLS); c++) begin
                e.addr = 11'(r * int'(COLS) + c);
                e.din  = 4'(tile);
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic drive_cmd(input int op, input int x, input int y, input int w,
                             input int h, input int tile);
        bus.cmd_op   = tile_op_t'(2'(op));
        bus.cmd_x    = 6'(x);
        bus.cmd_y    = 5'(y);
        bus.cmd_w    = 7'(w);
        bus.cmd_h    = 6'(h);
        bus.cmd_tile = 4'(tile);
    endtask

    // Present a command at a negedge while idle; returns just after the accept edge
    task automatic send(input int op, input int x, input int y, input int w,
                        input int h, input int tile);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.cmd_ready && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) check("ready_timeout", 0, 1);
        drive_cmd(op, x, y, w, h, tile);
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input int op, input int x, input int y,
                           input int w, input int h, input int tile);
        int n, cyc, wrs, rdy;
        bit got;
        push_expected(op, x, y, w, h, tile, n);
        send(op, x, y, w, h, tile);
        cyc = 1; wrs = 0; rdy = 0; got = 1'b0;
        while (cyc < 1500) begin
            if (bus.wr) wrs++;
            if (bus.cmd_ready) rdy++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!got) check({name, "_done_timeout"}, 0, 1);
        check({name, "_done_cyc"}, cyc, (n == 0) ? 1 : n + 1);
        check({name, "_wr_count"}, wrs, n);
        check({name, "_ready_low"}, rdy, 0);
        @(posedge clock);
        #1;
        check({name, "_done_pulse"}, 32'(bus.done), 0);
        check({name, "_ready_back"}, 32'(bus.cmd_ready), 1);
        check({name, "_busy_back"}, 32'(bus.busy), 0);
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic peek(input int a, output int v);
        addr2 = 11'(a);
        #1;
        v = 32'(dout2);
    endtask

    initial begin
        int v, n;
        int wr1, wr2, dn1, dn2, rdy1;
        exp_t e;

        n_tests = 0;
        n_fail  = 0;
        addr2   = '0;
        bus.cmd_valid = 1'b0;
        drive_cmd(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_wr", 32'(bus.wr), 0);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_din", 32'(bus.din), 0);
        check("rst_done", 32'(bus.done), 0);

        run_cmd("clear0", 0, 0, 0, 0, 0, 0);
        peek(0, v);    check("mem0_clear", v, 0);
        peek(1199, v); check("mem1199_clear", v, 0);

        run_cmd("put85", 2, 5, 2, 0, 0, 7);
        peek(85, v);   check("mem85", v, 7);

        run_cmd("fill_clip_right", 1, 38, 0, 5, 2, 3);
        peek(79, v);   check("mem79", v, 3);
        peek(40, v);   check("mem40_untouched", v, 0);

        run_cmd("fill_clip_bottom", 1, 0, 28, 2, 5, 12);
        peek(1161, v); check("mem1161", v, 12);

        run_cmd("empty_x40", 1, 40, 0, 3, 1, 5);
        run_cmd("empty_w0", 1, 3, 3, 0, 2, 5);
        run_cmd("empty_y30", 1, 0, 30, 2, 1, 5);
        run_cmd("empty_nop", 3, 1, 1, 2, 2, 5);

        // Reset lands while the write to address 10 is on the bus
        for (int i = 0; i < 10; i++) begin
            e.addr = 11'(i);
            e.din  = 4'd9;
            exp_q.push_back(e);
        end
        send(0, 0, 0, 0, 0, 9);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        check("rst_mid_addr", 32'(bus.addr), 10);
        check("rst_mid_wr_before", 32'(bus.wr), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_wr", 32'(bus.wr), 0);
        check("rst_mid_done", 32'(bus.done), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.wr) n++;
        end
        check("rst_mid_quiet", n, 0);
        check("rst_mid_ready", 32'(bus.cmd_ready), 1);
        check("rst_mid_drain", exp_q.size(), 0);
        for (int i = 0; i < 10; i++) begin
            peek(i, v);
            check("rst_mid_mem_written", v, 9);
        end
        peek(10, v);   check("rst_mid_mem10_old", v, 0);

        run_cmd("put_after_rst", 2, 1, 0, 0, 0, 5);
        peek(1, v);    check("mem1_after_rst", v, 5);

        // Back-to-back PUTs with cmd_valid held and cmd_x/tile changed mid-burst
        push_expected(2, 3, 4, 0, 0, 2, n);
        push_expected(2, 10, 4, 0, 0, 6, n);
        @(negedge clock);
        drive_cmd(2, 3, 4, 0, 0, 2);
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_x    = 6'd10;
        bus.cmd_tile = 4'd6;
        wr1 = 0; wr2 = 0; dn1 = 0; dn2 = 0; rdy1 = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (bus.wr) begin
                if (wr1 == 0) wr1 = cyc;
                else wr2 = cyc;
            end
            if (bus.done) begin
                if (dn1 == 0) dn1 = cyc;
                else dn2 = cyc;
            end
            if (bus.cmd_ready && rdy1 == 0) rdy1 = cyc;
            @(posedge clock);
            #1;
            if (rdy1 != 0) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        check("b2b_wr1_cyc", wr1, 1);
        check("b2b_done1_cyc", dn1, 2);
        check("b2b_ready_cyc", rdy1, 3);
        check("b2b_wr2_cyc", wr2, 4);
        check("b2b_done2_cyc", dn2, 5);
        check("b2b_drain", exp_q.size(), 0);
        peek(163, v);  check("b2b_mem163", v, 2);
        peek(170, v);  check("b2b_mem170", v, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
